mem_dbus: RTL and testbench

Memory-access stage placed directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It decodes load and store ALU ops and runs a request/acknowledge transaction on the data bus. While the transaction is outstanding it holds the pipeline through `stallreq_o`, then delivers the aligned, sign- or zero-extended load result toward write-back. Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_dbus.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_dbus.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus.sv
// Memory-access stage: decodes load/store ops, runs a req/ack data-bus transaction while
// stalling the pipeline, and aligns/extends load data toward write-back.
module mem_dbus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        stallreq_o,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic [31:0] wb_wdata_o,
  output logic        wb_whilo_o,
  output logic [31:0] wb_hi_o,
  output logic [31:0] wb_lo_o,
  output logic        addr_err_o,
  output logic        bus_err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;

  logic        is_load, is_store, misaligned, mem_ok;
  logic [3:0]  sel_c;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [1:0]  a_lo;

  assign a_lo = mem_addr_i[1:0];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    sel_c      = 4'b0000;
    st_wdata   = 32'h0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin
        is_load = 1'b1;
        sel_c   = 4'b1000 >> a_lo;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        is_load    = 1'b1;
        sel_c      = a_lo[1] ? 4'b0011 : 4'b1100;
        misaligned = a_lo[0];
      end
      EXE_LW_OP: begin
        is_load    = 1'b1;
        sel_c      = 4'b1111;
        misaligned = |a_lo;
      end
      EXE_SB_OP: begin
        is_store = 1'b1;
        sel_c    = 4'b1000 >> a_lo;
        st_wdata = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store   = 1'b1;
        sel_c      = a_lo[1] ? 4'b0011 : 4'b1100;
        st_wdata   = {2{reg2_i[15:0]}};
        misaligned = a_lo[0];
      end
      EXE_SW_OP: begin
        is_store   = 1'b1;
        sel_c      = 4'b1111;
        st_wdata   = reg2_i;
        misaligned = |a_lo;
      end
      default: ;
    endcase
  end

  assign mem_ok = (is_load | is_store) & ~misaligned;

  // Big-endian: address offset 0 lives in bits [31:24].
  always_comb begin
    case (a_lo)
      2'b00:   ld_byte = rbuf_q[31:24];
      2'b01:   ld_byte = rbuf_q[23:16];
      2'b10:   ld_byte = rbuf_q[15:8];
      default: ld_byte = rbuf_q[7:0];
    endcase
    ld_half = a_lo[1] ? rbuf_q[15:0] : rbuf_q[31:16];
    case (aluop_i)
      EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_data = {24'h0, ld_byte};
      EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_data = {16'h0, ld_half};
      default:    ld_data = rbuf_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    rbuf_d  = rbuf_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (mem_ok) begin
          state_d = StBusy;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {mem_addr_i[31:2], 2'b00};
          sel_d   = sel_c;
          wdata_d = st_wdata;
          cnt_d   = 8'h0;
          abort_d = 1'b0;
        end
      end
      StBusy: begin
        if (dbus_ack_i) begin
          rbuf_d  = dbus_rdata_i;
          req_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          abort_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'h0;
      abort_q <= 1'b0;
      rbuf_q  <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      rbuf_q  <= rbuf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  // Bus outputs are forced low while reset is asserted, ahead of the clearing edge.
  assign dbus_req_o   = req_q & ~rst;
  assign dbus_we_o    = we_q & ~rst;
  assign dbus_addr_o  = rst ? 32'h0 : addr_q;
  assign dbus_sel_o   = rst ? 4'h0 : sel_q;
  assign dbus_wdata_o = rst ? 32'h0 : wdata_q;

  always_comb begin
    wb_waddr_o = waddr_i;
    wb_we_o    = we_i & ~is_store & ~misaligned;
    wb_wdata_o = wdata_i;
    wb_whilo_o = whilo_i;
    wb_hi_o    = hi_i;
    wb_lo_o    = lo_i;
    stallreq_o = 1'b0;
    addr_err_o = misaligned;
    bus_err_o  = 1'b0;
    case (state_q)
      StIdle: stallreq_o = mem_ok;
      StBusy: stallreq_o = 1'b1;
      StDone: begin
        if (is_load) wb_wdata_o = ld_data;
        if (abort_q) begin
          wb_we_o   = 1'b0;
          bus_err_o = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      wb_waddr_o = 5'h0;
      wb_we_o    = 1'b0;
      wb_wdata_o = 32'h0;
      wb_whilo_o = 1'b0;
      wb_hi_o    = 32'h0;
      wb_lo_o    = 32'h0;
      stallreq_o = 1'b0;
      addr_err_o = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_dbus.sv
// Directed bench for mem_dbus: reset, sub-word loads, stores, misalignment, timeout and
// pass-through, with hand-computed expectations.
module tb_mem_dbus;

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpAdd = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i, lo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic [31:0] dbus_rdata_i;
  logic        dbus_ack_i;
  logic        stallreq_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_we_o;
  logic [31:0] wb_wdata_o;
  logic        wb_whilo_o;
  logic [31:0] wb_hi_o, wb_lo_o;
  logic        addr_err_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_dbus #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .waddr_i      (waddr_i),
    .we_i         (we_i),
    .wdata_i      (wdata_i),
    .whilo_i      (whilo_i),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .aluop_i      (aluop_i),
    .mem_addr_i   (mem_addr_i),
    .reg2_i       (reg2_i),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_sel_o   (dbus_sel_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_ack_i   (dbus_ack_i),
    .stallreq_o   (stallreq_o),
    .wb_waddr_o   (wb_waddr_o),
    .wb_we_o      (wb_we_o),
    .wb_wdata_o   (wb_wdata_o),
    .wb_whilo_o   (wb_whilo_o),
    .wb_hi_o      (wb_hi_o),
    .wb_lo_o      (wb_lo_o),
    .addr_err_o   (addr_err_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 unit after the edge; checks run 3 units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic nop();
    aluop_i = 8'h0; we_i = 1'b0; wdata_i = 32'h0; waddr_i = 5'h0; whilo_i = 1'b0;
    hi_i = 32'h0; lo_i = 32'h0; mem_addr_i = 32'h0; reg2_i = 32'h0;
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
  endtask

  task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2);
    nop();
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; we_i = 1'b1; waddr_i = 5'd5;
  endtask

  initial begin
    nop();
    rst = 1'b1;
    we_i = 1'b1; wdata_i = 32'h55; hi_i = 32'h11; whilo_i = 1'b1;
    tick(); tick(); settle();
    chk("rst_wb_we", 32'(wb_we_o), 32'h0);
    chk("rst_wb_wdata", wb_wdata_o, 32'h0);
    chk("rst_wb_hi", wb_hi_o, 32'h0);
    chk("rst_req", 32'(dbus_req_o), 32'h0);
    chk("rst_stall", 32'(stallreq_o), 32'h0);

    // Reset in the middle of a transaction.
    tick(); rst = 1'b0; mem_op(OpLw, 32'h100, 32'h0); settle();
    chk("rb_idle_stall", 32'(stallreq_o), 32'h1);
    tick(); settle();
    chk("rb_busy_req", 32'(dbus_req_o), 32'h1);
    chk("rb_busy_addr", dbus_addr_o, 32'h100);
    tick(); rst = 1'b1; settle();
    tick(); rst = 1'b0; nop(); settle();
    chk("rb_after_req", 32'(dbus_req_o), 32'h0);
    chk("rb_after_stall", 32'(stallreq_o), 32'h0);
    chk("rb_after_wb", {26'h0, wb_we_o, wb_waddr_o}, 32'h0);
    chk("rb_after_wdata", wb_wdata_o, 32'h0);
    tick(); mem_op(OpLw, 32'h104, 32'h0); settle();
    chk("lw_idle_stall", 32'(stallreq_o), 32'h1);
    tick(); settle();
    chk("lw_busy_addr", dbus_addr_o, 32'h104);
    chk("lw_busy_we", 32'(dbus_we_o), 32'h0);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEADBEEF;
    tick(); dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0; settle();
    chk("lw_done_stall", 32'(stallreq_o), 32'h0);
    chk("lw_done_wdata", wb_wdata_o, 32'hDEADBEEF);
    chk("lw_done_we", 32'(wb_we_o), 32'h1);

    // LB then LBU at 0x1003.
    for (int k = 0; k < 2; k++) begin
      tick(); mem_op((k == 0) ? OpLb : OpLbu, 32'h1003, 32'h0); settle();
      chk("lb_stall0", 32'(stallreq_o), 32'h1);
      tick(); settle();
      chk("lb_stall1", 32'(stallreq_o), 32'h1);
      chk("lb_sel", 32'(dbus_sel_o), 32'h1);
      chk("lb_addr", dbus_addr_o, 32'h1000);
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'h123456F0;
      tick(); dbus_ack_i = 1'b0; settle();
      chk("lb_done_stall", 32'(stallreq_o), 32'h0);
      chk("lb_done_wdata", wb_wdata_o, (k == 0) ? 32'hFFFFFFF0 : 32'h000000F0);
      chk("lb_done_we", 32'(wb_we_o), 32'h1);
    end

    // SH at 0x2002, ack in the third BUSY cycle.
    tick(); mem_op(OpSh, 32'h2002, 32'hAAAA5678); settle();
    chk("sh_stall0", 32'(stallreq_o), 32'h1);
    chk("sh_wb_we", 32'(wb_we_o), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick(); settle();
      if (c == 3) dbus_ack_i = 1'b1;
      chk("sh_stall", 32'(stallreq_o), 32'h1);
      chk("sh_req", 32'(dbus_req_o), 32'h1);
      chk("sh_bus_we", 32'(dbus_we_o), 32'h1);
      chk("sh_sel", 32'(dbus_sel_o), 32'h3);
      chk("sh_wdata", dbus_wdata_o, 32'h56785678);
    end
    tick(); dbus_ack_i = 1'b0; settle();
    chk("sh_done_stall", 32'(stallreq_o), 32'h0);
    chk("sh_done_req", 32'(dbus_req_o), 32'h0);
    chk("sh_done_we", 32'(wb_we_o), 32'h0);

    // Misaligned LW; a stray ack outside BUSY must not matter.
    tick(); mem_op(OpLw, 32'h3001, 32'h0); dbus_ack_i = 1'b1; settle();
    chk("mis_err", 32'(addr_err_o), 32'h1);
    chk("mis_stall", 32'(stallreq_o), 32'h0);
    chk("mis_we", 32'(wb_we_o), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      chk("mis_req", 32'(dbus_req_o), 32'h0);
    end

    // Timeout: req high for exactly 4 cycles.
    tick(); mem_op(OpLw, 32'h5000, 32'h0); settle();
    chk("to_stall0", 32'(stallreq_o), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      tick(); settle();
      chk("to_req", 32'(dbus_req_o), 32'h1);
      chk("to_no_berr", 32'(bus_err_o), 32'h0);
    end
    tick(); settle();
    chk("to_done_req", 32'(dbus_req_o), 32'h0);
    chk("to_done_berr", 32'(bus_err_o), 32'h1);
    chk("to_done_we", 32'(wb_we_o), 32'h0);
    chk("to_done_stall", 32'(stallreq_o), 32'h0);
    tick(); nop(); settle();
    chk("to_idle_berr", 32'(bus_err_o), 32'h0);

    // ADD pass-through then LHU.
    tick(); nop();
    aluop_i = OpAdd; we_i = 1'b1; wdata_i = 32'h55; whilo_i = 1'b1;
    hi_i = 32'h11; lo_i = 32'h22; waddr_i = 5'd3; settle();
    chk("add_stall", 32'(stallreq_o), 32'h0);
    chk("add_we", 32'(wb_we_o), 32'h1);
    chk("add_wdata", wb_wdata_o, 32'h55);
    chk("add_waddr", 32'(wb_waddr_o), 32'h3);
    chk("add_hilo", {wb_hi_o[15:0], wb_lo_o[15:0]}, 32'h00110022);
    chk("add_whilo", 32'(wb_whilo_o), 32'h1);
    tick(); mem_op(OpLhu, 32'h4000, 32'h0); settle();
    chk("lhu_stall0", 32'(stallreq_o), 32'h1);
    tick(); settle();
    chk("lhu_sel", 32'(dbus_sel_o), 32'hC);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h8001FFFF;
    tick(); dbus_ack_i = 1'b0; settle();
    chk("lhu_wdata", wb_wdata_o, 32'h00008001);
    chk("lhu_we", 32'(wb_we_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
